// File: rtl/mdu_ctrl_if.sv
// rtl/mdu_ctrl_if.sv - multiply/divide unit issue and register-file bus
interface mdu_ctrl_if;
  logic [31:0] A;
  logic [31:0] B;
  logic [3:0]  MduOp;
  logic        Start;
  logic        Req;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [31:0] Out;

  modport master (
    output A, B, MduOp, Start, Req,
    input  Busy, HI, LO, Out
  );

  modport slave (
    input  A, B, MduOp, Start, Req,
    output Busy, HI, LO, Out
  );
endinterface

// File: rtl/mdu_ctrl.sv
// rtl/mdu_ctrl.sv - multi-cycle MULT/DIV controller with HI/LO registers
module mdu_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  mdu_ctrl_if.slave   bus
);
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] thi_q, thi_d, tlo_q, tlo_d;

  logic [63:0] mul_s, mul_u;
  logic [31:0] a_mag, b_mag, q_mag, r_mag;
  logic [31:0] divs_q, divs_r, divu_q, divu_r;
  logic        is_long_op, issue;

  assign mul_s = {{32{bus.A[31]}}, bus.A} * {{32{bus.B[31]}}, bus.B};
  assign mul_u = {32'd0, bus.A} * {32'd0, bus.B};

  // Signed divide via magnitudes so 0x80000000 / -1 yields 0x80000000 without overflow.
  assign a_mag  = bus.A[31] ? (~bus.A + 32'd1) : bus.A;
  assign b_mag  = bus.B[31] ? (~bus.B + 32'd1) : bus.B;
  assign q_mag  = (b_mag == 32'd0) ? 32'd0 : a_mag / b_mag;
  assign r_mag  = (b_mag == 32'd0) ? 32'd0 : a_mag % b_mag;
  assign divs_q = (bus.A[31] ^ bus.B[31]) ? (~q_mag + 32'd1) : q_mag;
  assign divs_r = bus.A[31] ? (~r_mag + 32'd1) : r_mag;
  assign divu_q = (bus.B == 32'd0) ? 32'd0 : bus.A / bus.B;
  assign divu_r = (bus.B == 32'd0) ? 32'd0 : bus.A % bus.B;

  assign is_long_op = (bus.MduOp == OP_MULT) || (bus.MduOp == OP_MULTU) ||
                      (bus.MduOp == OP_DIV)  || (bus.MduOp == OP_DIVU);
  assign issue      = (state_q == IDLE) && bus.Start && !bus.Req && is_long_op;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 16'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      thi_q   <= 32'd0;
      tlo_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      thi_q   <= thi_d;
      tlo_q   <= tlo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (issue) state_d = RUN;
      RUN:     if (cnt_q <= 16'd1) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    hi_d  = hi_q;
    lo_d  = lo_q;
    thi_d = thi_q;
    tlo_d = tlo_q;
    if (state_q == RUN) begin
      cnt_d = cnt_q - 16'd1;
      if (cnt_q <= 16'd1) begin
        cnt_d = 16'd0;
        hi_d  = thi_q;
        lo_d  = tlo_q;
      end
    end else if (issue) begin
      // Divide by zero captures the current HI/LO so the commit is a no-op.
      case (bus.MduOp)
        OP_MULT:  begin thi_d = mul_s[63:32]; tlo_d = mul_s[31:0]; end
        OP_MULTU: begin thi_d = mul_u[63:32]; tlo_d = mul_u[31:0]; end
        OP_DIV:   begin
          thi_d = (bus.B == 32'd0) ? hi_q : divs_r;
          tlo_d = (bus.B == 32'd0) ? lo_q : divs_q;
        end
        default:  begin
          thi_d = (bus.B == 32'd0) ? hi_q : divu_r;
          tlo_d = (bus.B == 32'd0) ? lo_q : divu_q;
        end
      endcase
      cnt_d = ((bus.MduOp == OP_MULT) || (bus.MduOp == OP_MULTU)) ?
              16'(MULT_CYCLES) : 16'(DIV_CYCLES);
    end else if (!bus.Req) begin
      if (bus.MduOp == OP_MTHI) hi_d = bus.A;
      if (bus.MduOp == OP_MTLO) lo_d = bus.A;
    end
  end

  always_comb begin
    bus.Busy = (state_q == RUN);
    bus.HI   = hi_q;
    bus.LO   = lo_q;
    case (bus.MduOp)
      OP_MFHI: bus.Out = hi_q;
      OP_MFLO: bus.Out = lo_q;
      default: bus.Out = 32'd0;
    endcase
  end
endmodule

// File: tb/tb_mdu_ctrl.sv
// tb/tb_mdu_ctrl.sv - scoreboard bench for mdu_ctrl
module tb_mdu_ctrl;
  logic clk;
  logic reset;
  mdu_ctrl_if bus ();

  mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    string       tag;
    bit          snap;
    int          busy_n;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    bit          chk_out;
    logic [31:0] out;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  // Monitor: snapshots are checked on the next falling edge, ops when Busy drops.
  initial begin : monitor
    int   cnt;
    logic prev;
    exp_t e;
    cnt  = 0;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.Busy) cnt++;
      if (exp_q.size() > 0 && exp_q[0].snap) begin
        e = exp_q.pop_front();
        chk({e.tag, ".busy"}, {31'd0, bus.Busy}, {31'd0, e.busy});
        chk({e.tag, ".hi"}, bus.HI, e.hi);
        chk({e.tag, ".lo"}, bus.LO, e.lo);
        if (e.chk_out) chk({e.tag, ".out"}, bus.Out, e.out);
      end else if (prev && !bus.Busy && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk({e.tag, ".busy_cycles"}, cnt, e.busy_n);
        chk({e.tag, ".hi"}, bus.HI, e.hi);
        chk({e.tag, ".lo"}, bus.LO, e.lo);
      end
      if (!bus.Busy) cnt = 0;
      prev = bus.Busy;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic start, input logic req);
    bus.MduOp = op;
    bus.A     = a;
    bus.B     = b;
    bus.Start = start;
    bus.Req   = req;
    cyc();
    bus.MduOp = 4'd0;
    bus.Start = 1'b0;
    bus.Req   = 1'b0;
  endtask

  task automatic push_op(input string tag, input int n, input logic [31:0] hi, input logic [31:0] lo);
    exp_t e;
    e.tag = tag; e.snap = 1'b0; e.busy_n = n; e.busy = 1'b0;
    e.hi = hi; e.lo = lo; e.chk_out = 1'b0; e.out = 32'd0;
    exp_q.push_back(e);
  endtask

  task automatic push_snap(input string tag, input logic busy, input logic [31:0] hi,
                           input logic [31:0] lo, input bit chk_out, input logic [31:0] out);
    exp_t e;
    e.tag = tag; e.snap = 1'b1; e.busy_n = 0; e.busy = busy;
    e.hi = hi; e.lo = lo; e.chk_out = chk_out; e.out = out;
    exp_q.push_back(e);
  endtask

  task automatic finish_op(input string tag);
    for (int i = 0; i < 60; i++) begin
      if (!bus.Busy) break;
      cyc();
    end
    if (bus.Busy) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s.timeout: Busy still 1 after 60 cycles, required 0", tag);
    end
    cyc();
  endtask

  initial begin : stimulus
    reset     = 1'b1;
    bus.A     = 32'd0;
    bus.B     = 32'd0;
    bus.MduOp = 4'd0;
    bus.Start = 1'b0;
    bus.Req   = 1'b0;
    cyc();
    push_snap("reset_state", 1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
    cyc();
    reset = 1'b0;
    cyc();

    drive(4'd1, 32'hFFFF_FFFE, 32'd3, 1'b1, 1'b0);
    push_op("mult_signed", 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    finish_op("mult_signed");
    bus.MduOp = 4'd8;
    push_snap("mflo", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b1, 32'hFFFF_FFFA);
    cyc();

    drive(4'd2, 32'hFFFF_FFFF, 32'd2, 1'b1, 1'b0);
    push_op("multu", 5, 32'h0000_0001, 32'hFFFF_FFFE);
    finish_op("multu");

    drive(4'd3, 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0);
    push_op("div_neg", 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    finish_op("div_neg");

    drive(4'd3, 32'd55, 32'd0, 1'b1, 1'b0);
    push_op("div_by_zero", 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    finish_op("div_by_zero");

    drive(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0);
    push_op("div_ovf", 10, 32'h0000_0000, 32'h8000_0000);
    finish_op("div_ovf");

    drive(4'd4, 32'hFFFF_FFFF, 32'h0000_0010, 1'b1, 1'b0);
    push_op("divu", 10, 32'h0000_000F, 32'h0FFF_FFFF);
    finish_op("divu");

    // Start DIVU and MTHI while the MULT is in flight; both must be dropped.
    drive(4'd1, 32'd7, 32'd6, 1'b1, 1'b0);
    push_op("mult_busy_ign", 5, 32'd0, 32'h0000_002A);
    cyc();
    drive(4'd4, 32'd100, 32'd7, 1'b1, 1'b0);
    drive(4'd5, 32'h0000_1234, 32'd0, 1'b0, 1'b0);
    finish_op("mult_busy_ign");
    push_snap("no_relaunch", 1'b0, 32'd0, 32'h0000_002A, 1'b0, 32'd0);
    cyc();

    drive(4'd1, 32'd5, 32'd5, 1'b1, 1'b1);
    push_snap("start_req_blk", 1'b0, 32'd0, 32'h0000_002A, 1'b0, 32'd0);
    cyc();

    drive(4'd6, 32'h0000_ABCD, 32'd0, 1'b0, 1'b0);
    push_snap("mtlo", 1'b0, 32'd0, 32'h0000_ABCD, 1'b0, 32'd0);
    cyc();
    drive(4'd5, 32'h0000_1357, 32'd0, 1'b0, 1'b0);
    push_snap("mthi", 1'b0, 32'h0000_1357, 32'h0000_ABCD, 1'b0, 32'd0);
    cyc();
    drive(4'd5, 32'h0000_5555, 32'd0, 1'b0, 1'b1);
    push_snap("mthi_req_blk", 1'b0, 32'h0000_1357, 32'h0000_ABCD, 1'b0, 32'd0);
    cyc();

    bus.MduOp = 4'd7;
    bus.Start = 1'b1;
    cyc();
    bus.Start = 1'b0;
    push_snap("start_mfhi_ign", 1'b0, 32'h0000_1357, 32'h0000_ABCD, 1'b1, 32'h0000_1357);
    cyc();
    bus.MduOp = 4'd12;
    push_snap("out_none", 1'b0, 32'h0000_1357, 32'h0000_ABCD, 1'b1, 32'd0);
    cyc();
    bus.MduOp = 4'd0;

    drive(4'd3, 32'd100, 32'd3, 1'b1, 1'b0);
    cyc();
    cyc();
    cyc();
    reset = 1'b1;
    push_snap("rst_async", 1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
    cyc();
    reset = 1'b0;
    drive(4'd2, 32'd3, 32'd4, 1'b1, 1'b0);
    push_op("start_after_rst", 5, 32'd0, 32'h0000_000C);
    finish_op("start_after_rst");
    repeat (12) cyc();
    push_snap("no_late_wb", 1'b0, 32'd0, 32'h0000_000C, 1'b0, 32'd0);
    cyc();

    for (int i = 0; i < 100; i++) begin
      if (exp_q.size() == 0) break;
      cyc();
    end
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/mdu_ctrl.md
MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 SHALL provide parameter MULT_CYCLES, default 5: busy cycles for MULT/MULTU.
REQ-002 SHALL provide parameter DIV_CYCLES, default 10: busy cycles for DIV/DIVU.
REQ-003 SHALL have clk  input  1  the single clock; all state updates on rising edge.
REQ-004 SHALL have reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have A  input  32  operand rs (dividend / multiplicand).
REQ-006 SHALL have B  input  32  operand rt (divisor / multiplier).
REQ-007 SHALL have MduOp  input  4  op code: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MFHI, 8 MFLO; 9-15 treated as NONE.
REQ-008 SHALL have Start  input  1  one-cycle pulse launching MULT/MULTU/DIV/DIVU.
REQ-009 SHALL have Req  input  1  exception/interrupt flush; suppresses issue in the current cycle.
REQ-010 SHALL have Busy  output  1  operation in flight.
REQ-011 SHALL have HI  output  32  HI register.
REQ-012 SHALL have LO  output  32  LO register.
REQ-013 SHALL have Out  output  32  MFHI/MFLO read data.

Function
REQ-014 SHALL implement two states: IDLE (Busy=0) and RUN (Busy=1).
REQ-015 In IDLE, Start=1, Req=0 and MduOp in {1,2,3,4} SHALL latch the result into internal temp HI/LO, load a counter with MULT_CYCLES or DIV_CYCLES, and move to RUN at that edge.
REQ-016 Busy SHALL be 1 for exactly N consecutive cycles beginning the cycle after Start (N = MULT_CYCLES or DIV_CYCLES).
REQ-017 HI/LO SHALL take the temp values at the edge ending the Nth busy cycle; the state returns to IDLE at that same edge.
REQ-018 Start SHALL be ignored while in RUN; no relaunch and no counter reload.
REQ-019 Start with MduOp outside {1,2,3,4} SHALL be ignored.
REQ-020 MULT SHALL compute the signed 64-bit product: {HI,LO} = $signed(A)*$signed(B). MULTU SHALL compute the same unsigned.
REQ-021 DIV SHALL produce LO = signed quotient truncated toward zero and HI = remainder carrying the dividend's sign. DIVU SHALL produce the unsigned quotient and remainder.
REQ-022 DIV 0x80000000 / 0xFFFFFFFF SHALL give LO=0x80000000, HI=0.
REQ-023 A divide with B=0 SHALL still run DIV_CYCLES busy cycles and leave HI/LO unchanged.
REQ-024 MTHI/MTLO SHALL write A to HI/LO at the next edge only when in IDLE and Req=0. Either op during RUN SHALL be ignored; hazard logic stalls it upstream.
REQ-025 Out SHALL be combinational: HI when MduOp=MFHI, LO when MduOp=MFLO, otherwise 0. It reflects committed registers, never temp values.
REQ-026 Req=1 SHALL block issue of Start/MTHI/MTLO in that cycle. Req during RUN SHALL NOT abort the in-flight operation, because it belongs to an older, committed instruction.

Reset
REQ-027 reset=1 SHALL immediately, without a clock edge, force IDLE, Busy=0, HI=0, LO=0, counter=0 and temp=0.
REQ-028 reset asserted mid-RUN SHALL discard the pending result; HI/LO stay 0 after release.
REQ-029 After reset is released, the first rising edge SHALL accept Start normally.

Verification
REQ-030 MULT A=0xFFFFFFFE, B=3, Start pulse -> Busy high 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA; MFLO Out=0xFFFFFFFA.
REQ-031 MULTU A=0xFFFFFFFF, B=2 -> HI=0x00000001, LO=0xFFFFFFFE after 5 busy cycles.
REQ-032 DIV A=-7 (0xFFFFFFF9), B=2 -> Busy 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF. Then DIV B=0 -> 10 busy cycles, HI/LO unchanged.
REQ-033 Start MULT, then Start DIVU and MTHI 0x1234 during busy cycle 3 -> both ignored; Busy drops after cycle 5 with the MULT result only.
REQ-034 Start together with Req=1 -> Busy stays 0 and HI/LO unchanged. MTLO 0xABCD with Req=0 -> LO=0xABCD next edge.
REQ-035 reset pulsed during DIV busy cycle 4 -> Busy=0 and HI=LO=0 immediately; no late write-back afterwards.
